// File: rtl/rgb2y_pkg.sv
// Shared constants for the RGB-to-luma pipeline.
package rgb2y_pkg;

    localparam int COEF_W    = 18;      // Q0.17 signed weights
    localparam int FRAC_BITS = 17;
    localparam int ONE       = 131072;  // 1.0 in Q0.17
    localparam int HALF      = 65536;   // 0.5 in Q0.17, rounding offset
    localparam int LATENCY   = 4;

    localparam int PIX_W  = 8;
    localparam int KG_W   = COEF_W + 1; // kg may exceed 1.0
    localparam int PROD_W = 28;
    localparam int SUM_W  = 30;
    localparam int RND_W  = SUM_W + 1;  // headroom for the rounding add
    localparam int CTRL_W = 3;          // {dv, hs, vs}

endpackage

// File: rtl/rgb2y_ctrl_delay.sv
// Delays the {dv, hs, vs} control bundle by LATENCY cycles to match the datapath.
module rgb2y_ctrl_delay
    import rgb2y_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic [LATENCY-1:0][CTRL_W-1:0] pipe_q;

    // Shift register; reset discards any in-flight control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[LATENCY-2:0], ctrl_i};
        end
    end

    assign ctrl_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/rgb2y.sv
// Four-stage RGB to luma converter with run-time programmable Q0.17 weights.
module rgb2y
    import rgb2y_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [COEF_W-1:0] kr_i,
    input  logic signed [COEF_W-1:0] kb_i,
    input  logic                     dv_i,
    input  logic                     hs_i,
    input  logic                     vs_i,
    input  logic        [PIX_W-1:0]  r_i,
    input  logic        [PIX_W-1:0]  g_i,
    input  logic        [PIX_W-1:0]  b_i,
    output logic                     dv_o,
    output logic                     hs_o,
    output logic                     vs_o,
    output logic        [PIX_W-1:0]  y_o
);

    localparam logic signed [KG_W-1:0]  KgOne   = KG_W'(ONE);
    localparam logic signed [RND_W-1:0] RndHalf = RND_W'(HALF);
    localparam logic signed [RND_W-1:0] YMax    = RND_W'(255);

    // Stage 1: sampled inputs and derived green weight.
    logic signed [COEF_W-1:0] kr_q, kb_q;
    logic signed [KG_W-1:0]   kg_d, kg_q;
    logic signed [PIX_W:0]    r_q, g_q, b_q;   // zero-extended to signed 9 bits

    // Stage 2: products. Stage 3: sum. Stage 4: rounded, clamped luma.
    logic signed [PROD_W-1:0] pr_d, pg_d, pb_d, pr_q, pg_q, pb_q;
    logic signed [SUM_W-1:0]  sum_d, sum_q;
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  shifted;
    logic        [PIX_W-1:0]  y_d, y_q;

    assign kg_d = KgOne - KG_W'(kr_i) - KG_W'(kb_i);

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kr_q <= '0;
            kb_q <= '0;
            kg_q <= '0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            kr_q <= kr_i;
            kb_q <= kb_i;
            kg_q <= kg_d;
            r_q  <= {1'b0, r_i};
            g_q  <= {1'b0, g_i};
            b_q  <= {1'b0, b_i};
        end
    end

    // Operands are widened before multiplying so the products map onto DSP slices.
    assign pr_d = PROD_W'(kr_q) * PROD_W'(r_q);
    assign pg_d = PROD_W'(kg_q) * PROD_W'(g_q);
    assign pb_d = PROD_W'(kb_q) * PROD_W'(b_q);

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q <= '0;
            pg_q <= '0;
            pb_q <= '0;
        end else begin
            pr_q <= pr_d;
            pg_q <= pg_d;
            pb_q <= pb_d;
        end
    end

    assign sum_d = SUM_W'(pr_q) + SUM_W'(pg_q) + SUM_W'(pb_q);

    // Stage 3 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // Round half-up, floor-shift, then saturate into 0..255.
    always_comb begin
        rnd     = RND_W'(sum_q) + RndHalf;
        shifted = rnd >>> FRAC_BITS;
        y_d     = '0;
        if (shifted < 0) begin
            y_d = '0;
        end else if (shifted > YMax) begin
            y_d = '1;
        end else begin
            y_d = shifted[PIX_W-1:0];
        end
    end

    // Stage 4 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

    rgb2y_ctrl_delay u_ctrl_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctrl_i ({dv_i, hs_i, vs_i}),
        .ctrl_o ({dv_o, hs_o, vs_o})
    );

endmodule

// File: tb/tb_rgb2y.sv
// Self-checking bench for rgb2y: directed vectors, random frame, mid-frame reset.
module tb_rgb2y;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [17:0] kr_i, kb_i;
    logic               dv_i, hs_i, vs_i;
    logic        [7:0]  r_i, g_i, b_i;
    logic               dv_o, hs_o, vs_o;
    logic        [7:0]  y_o;

    int compared   = 0;
    int mismatched = 0;
    int dv_count   = 0;

    // Expected {dv, hs, vs, y} per input cycle, oldest first.
    logic [10:0] expq[$];

    rgb2y dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kr_i  (kr_i),
        .kb_i  (kb_i),
        .dv_i  (dv_i),
        .hs_i  (hs_i),
        .vs_i  (vs_i),
        .r_i   (r_i),
        .g_i   (g_i),
        .b_i   (b_i),
        .dv_o  (dv_o),
        .hs_o  (hs_o),
        .vs_o  (vs_o),
        .y_o   (y_o)
    );

    always #5 clk = ~clk;

    // Luma from the formula with plain integer arithmetic and floor division.
    function automatic int ref_y(input int kr, input int kb, input int r, input int g,
                                 input int b);
        longint kg, s, t, q;
        kg = 131072 - kr - kb;
        s  = longint'(kr) * r + kg * g + longint'(kb) * b;
        t  = s + 65536;
        if (t >= 0) q = t / 131072;
        else        q = -((-t + 131071) / 131072);
        if (q < 0)   q = 0;
        if (q > 255) q = 255;
        return int'(q);
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got dv/hs/vs/y=%b%b%b/%0d want %b%b%b/%0d", tag,
                   obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // One input cycle; exp_y < 0 means take the expected luma from the model.
    task automatic step(input int kr, input int kb, input bit dv, input bit hs, input bit vs,
                        input int r, input int g, input int b, input int exp_y,
                        input string tag);
        int          y;
        logic [10:0] e;
        kr_i = 18'(kr);
        kb_i = 18'(kb);
        dv_i = dv;
        hs_i = hs;
        vs_i = vs;
        r_i  = 8'(r);
        g_i  = 8'(g);
        b_i  = 8'(b);
        y    = (exp_y < 0) ? ref_y(kr, kb, r, g, b) : exp_y;
        expq.push_back({dv, hs, vs, 8'(y)});
        @(posedge clk);
        #1;
        if (dv_o) dv_count++;
        if (expq.size() == 4) begin
            e = expq.pop_front();
            check(tag, {dv_o, hs_o, vs_o, y_o}, e);
        end
    endtask

    // Outputs from cleared pipeline registers are all zero.
    task automatic prefill_zero();
        expq.delete();
        for (int i = 0; i < 3; i++) expq.push_back(11'd0);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(27865, 9463, 1'b0, 1'b0, 1'b0, 0, 0, 0, -1, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        kr_i  = '0;
        kb_i  = '0;
        dv_i  = 1'b0;
        hs_i  = 1'b0;
        vs_i  = 1'b0;
        r_i   = '0;
        g_i   = '0;
        b_i   = '0;

        // Reset state.
        #3;
        check("reset_async", {dv_o, hs_o, vs_o, y_o}, 11'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {dv_o, hs_o, vs_o, y_o}, 11'd0);
        rst_n = 1'b1;
        prefill_zero();

        // White pixel, then primaries back-to-back with known luma.
        step(27865, 9463, 1'b1, 1'b0, 1'b0, 255, 255, 255, 255, "white");
        step(27865, 9463, 1'b1, 1'b0, 1'b0, 255, 0, 0, 54, "red");
        step(27865, 9463, 1'b1, 1'b0, 1'b0, 0, 255, 0, 182, "green");
        step(27865, 9463, 1'b1, 1'b0, 1'b0, 0, 0, 255, 18, "blue");
        // Saturation with negative red weight and kg above 1.0.
        step(-20000, 0, 1'b1, 1'b0, 1'b0, 255, 0, 0, 0, "sat_low");
        step(-20000, 0, 1'b1, 1'b0, 1'b0, 0, 255, 0, 255, "sat_high");
        // Datapath runs with dv_i low; control bits pass through independently.
        step(27865, 9463, 1'b0, 1'b1, 1'b0, 100, 150, 200, -1, "dv_low");
        step(27865, 9463, 1'b0, 1'b0, 1'b1, 1, 2, 3, -1, "vs_only");
        idle(4, "flush");

        // Small frame: 16 active pixels per 20-cycle line, 8 lines, random pixels and
        // per-cycle random weights; hs/vs pulses sit in blanking.
        dv_count = 0;
        for (int ln = 0; ln < 8; ln++) begin
            for (int x = 0; x < 20; x++) begin
                int kr, kb;
                kr = int'($urandom_range(120000, 0)) - 40000;
                kb = int'($urandom_range(120000, 0)) - 40000;
                step(kr, kb, x < 16, x == 17, (ln == 0) && (x >= 16),
                     int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                     int'($urandom_range(255, 0)), -1, "frame");
            end
        end
        idle(4, "frame_flush");
        compared++;
        assert (dv_count == 128) else begin
            mismatched++;
            $error("FAIL frame_dv_count: got %0d want %0d", dv_count, 128);
        end

        // Reset mid-line with valid pixels in flight.
        for (int i = 0; i < 6; i++) begin
            step(27865, 9463, 1'b1, 1'b0, 1'b0, int'($urandom_range(255, 0)),
                 int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), -1, "pre_rst");
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_async", {dv_o, hs_o, vs_o, y_o}, 11'd0);
        @(posedge clk);
        #1;
        check("midreset_held", {dv_o, hs_o, vs_o, y_o}, 11'd0);
        #2;
        rst_n = 1'b1;
        prefill_zero();
        idle(2, "post_rst_idle");
        for (int i = 0; i < 10; i++) begin
            step(int'($urandom_range(120000, 0)) - 40000, int'($urandom_range(120000, 0)) - 40000,
                 1'b1, i == 9, 1'b0, int'($urandom_range(255, 0)),
                 int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), -1, "post_rst");
        end
        idle(4, "final_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rgb2y.md
RGB2Y -- requirements
Module: rgb2y

Interface
REQ-001 The block SHALL have no parameters; all widths and the latency SHALL be fixed constants.
REQ-002 The ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, the single clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- kr_i, in, 18 signed, red weight, Q0.17 (2^17 = 131072 represents 1.0).
- kb_i, in, 18 signed, blue weight, Q0.17.
- dv_i, in, 1, input pixel valid.
- hs_i, in, 1, horizontal sync.
- vs_i, in, 1, vertical sync.
- r_i, in, 8 unsigned, red.
- g_i, in, 8 unsigned, green.
- b_i, in, 8 unsigned, blue.
- dv_o, out, 1, dv_i delayed by the pipeline latency.
- hs_o, out, 1, hs_i delayed by the pipeline latency.
- vs_o, out, 1, vs_i delayed by the pipeline latency.
- y_o, out, 8 unsigned, luma.
REQ-003 The clock/reset scheme SHALL be: one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-004 The block SHALL derive kg = 131072 - kr - kb as a 19-bit signed value, computed from the sampled kr_i/kb_i each cycle.
REQ-005 The block SHALL compute S = kr*R + kg*G + kb*B with R/G/B zero-extended to signed 9 bits; products SHALL be 28-bit signed and the sum 30-bit signed, with no intermediate overflow.
REQ-006 The block SHALL set y_o = clamp((S + 65536) >>> 17, 0, 255), using an arithmetic shift with round-half-up.
REQ-007 The pipeline SHALL be 4 stages:
- stage 1: register inputs and compute kg;
- stage 2: three products;
- stage 3: sum;
- stage 4: round and clamp.
REQ-008 Latency SHALL be exactly 4 clk cycles from inputs to y_o, dv_o, hs_o and vs_o; control and data SHALL stay aligned.
REQ-009 The datapath SHALL compute every cycle regardless of dv_i; y_o is don't-care when dv_o=0 but SHALL still equal the formula applied to the inputs from 4 cycles earlier.
REQ-010 The block SHALL have no handshake and no backpressure; it SHALL accept one pixel per cycle at full rate.
REQ-011 Coefficient changes SHALL take effect for the pixel sampled in the same cycle; no frame-boundary latching.
REQ-012 Negative kr/kb and kg > 1.0 SHALL be legal; a negative result SHALL saturate to 0 and a result > 255 SHALL saturate to 255.

Reset
REQ-013 rst_n=0 SHALL asynchronously clear all pipeline registers; dv_o, hs_o, vs_o and y_o SHALL all be 0 while reset is asserted.
REQ-014 After rst_n deasserts, the outputs SHALL stay 0 until pixels sampled after reset reach the output 4 cycles later; reset mid-frame SHALL discard in-flight pixels.

Structure
REQ-015 Package rgb2y_pkg SHALL hold the shared constants: COEF_W=18, FRAC_BITS=17, ONE=131072, HALF=65536, LATENCY=4.
REQ-016 A single sub-module, rgb2y_ctrl_delay, SHALL implement the 3-bit {dv, hs, vs} LATENCY-deep shift register with async reset; the arithmetic SHALL stay in rgb2y.
REQ-017 Implementation SHALL be 120-400 lines of RTL and SHALL infer DSP multipliers; the block SHALL contain no latches.

Verification (kr=27865, kb=9463, so kg=93744, unless stated)
REQ-018 R=G=B=255, dv_i=1 -> y_o=255 and dv_o=1 exactly 4 cycles later.
REQ-019 Separate pixels (255,0,0), (0,255,0) and (0,0,255) -> y_o = 54, 182 and 18 respectively, back-to-back on consecutive cycles.
REQ-020 Saturation with kr=-20000, kb=0: (255,0,0) -> y_o=0; (0,255,0) -> y_o=255.
REQ-021 Streaming 512x512 frame with hs/vs pulses in blanking -> dv_o/hs_o/vs_o equal the inputs shifted by exactly 4 cycles; 262144 dv_o cycles per frame; y_o matches a bit-exact software model.
REQ-022 Assert rst_n low mid-line with dv_i=1 -> all outputs 0 immediately (asynchronously); after release, the first dv_o=1 occurs 4 cycles after the first dv_i=1 sampled.
